mmio_io_bridge: RTL and testbench

//  Data-memory-side responder for the processor's memory-mapped I/O. Sits between processor
//  (address_dmem/wren/data/q_dmem) and RAM. Serves loads from button event registers, serves

---
 rtl/mmio_io_bridge.sv | 191 +++++++++++++++++++
 tb/tb_mmio_io_bridge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_bridge.sv
// -----------------------------------------------------------------------------
// mmio_io_bridge
//
// Data-memory-side responder for the processor's memory-mapped I/O. It sits
// between the processor data port and the data RAM and provides:
//   * clear-on-read event registers for the five debounced buttons,
//   * a store-fed output FIFO that the VGA controller drains,
//   * a status word {drop_cnt, 8'b0, fifo_level},
//   * RAM write gating so MMIO stores never reach the RAM.
//
// Ports
//   clock         in   1   processor clock; all state updates on posedge
//   reset         in   1   synchronous, active-high
//   address_dmem  in   32  processor data address
//   wren          in   1   processor store strobe (load when low)
//   data          in   32  processor store data
//   q_ram         in   32  RAM read data (1-cycle read latency)
//   q_dmem        out  32  load data to processor, valid 1 cycle after address
//   ram_wren      out  1   RAM write enable, suppressed for MMIO addresses
//   btn           in   5   debounced button levels {D,U,R,L,C}
//   out_data      out  32  FIFO head word (0 when empty)
//   out_valid     out  1   FIFO non-empty
//   out_ready     in   1   consumer accepts head when out_valid & out_ready
// -----------------------------------------------------------------------------
module mmio_io_bridge #(
   parameter logic [31:0] BTNC_ADDR = 32'd1000,
   parameter logic [31:0] OUT_ADDR  = 32'd2000,
   parameter logic [31:0] BTNL_ADDR = 32'd3000,
   parameter logic [31:0] BTNR_ADDR = 32'd4000,
   parameter logic [31:0] BTNU_ADDR = 32'd5000,
   parameter logic [31:0] BTND_ADDR = 32'd6000,
   parameter logic [31:0] STAT_ADDR = 32'd2004,
   parameter int          OUT_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address_dmem,
   input  logic        wren,
   input  logic [31:0] data,
   input  logic [31:0] q_ram,
   output logic [31:0] q_dmem,
   output logic        ram_wren,
   input  logic [4:0]  btn,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int         PTR_W   = $clog2(OUT_DEPTH);
   localparam logic [7:0] DEPTH_L = 8'(OUT_DEPTH);

   // ---------------------------------------------------------------------------
   // Address decode (full 32-bit compares)
   // ---------------------------------------------------------------------------
   logic [4:0] btn_sel;     // one-hot per button register, bit order {D,U,R,L,C}
   logic       hit_out;
   logic       hit_stat;
   logic       mmio_hit;
   logic       ld;

   assign btn_sel  = {address_dmem == BTND_ADDR,
                      address_dmem == BTNU_ADDR,
                      address_dmem == BTNR_ADDR,
                      address_dmem == BTNL_ADDR,
                      address_dmem == BTNC_ADDR};
   assign hit_out  = (address_dmem == OUT_ADDR);
   assign hit_stat = (address_dmem == STAT_ADDR);
   assign mmio_hit = (|btn_sel) | hit_out | hit_stat;
   assign ld       = ~wren;

   assign ram_wren = wren & ~mmio_hit;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [4:0]       btn_prev_q;
   logic [4:0]       pending_q,  pending_d;
   logic             rd_sel_q,   rd_sel_d;
   logic [31:0]      rd_val_q,   rd_val_d;
   logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
   logic [7:0]       level_q,    level_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic [31:0]      mem_q [OUT_DEPTH];

   // ---------------------------------------------------------------------------
   // Button events
   // ---------------------------------------------------------------------------
   logic [4:0] rise;
   logic [4:0] clr;

   assign rise = btn & ~btn_prev_q;
   assign clr  = btn_sel & {5{ld}};

   // OR-ing the rise in after the clear makes a same-cycle rise win over the
   // clear-on-read, so an event arriving during the read is never lost.
   assign pending_d = (pending_q & ~clr) | rise;

   // ---------------------------------------------------------------------------
   // Output FIFO control
   // ---------------------------------------------------------------------------
   logic push_req;
   logic pop;
   logic full;
   logic push;
   logic drop;

   assign out_valid = (level_q != 8'd0);
   assign pop       = out_valid & out_ready;
   assign full      = (level_q == DEPTH_L);
   assign push_req  = wren & hit_out;
   // A full FIFO still accepts a store when the head leaves in the same cycle.
   assign push      = push_req & (~full | pop);
   assign drop      = push_req & full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + 8'd1;
         2'b01:   level_d = level_q - 8'd1;
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   assign out_data = out_valid ? mem_q[rd_ptr_q] : 32'd0;

   // ---------------------------------------------------------------------------
   // Load path: MMIO word is captured at the edge, matching RAM read latency
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_sel_d = ld & mmio_hit;
      rd_val_d = 32'd0;
      if (hit_stat) begin
         rd_val_d = {drop_cnt_q, 8'h00, level_q};
      end else if (|btn_sel) begin
         // Pre-clear value of the addressed event bit.
         rd_val_d = {31'd0, |(pending_q & btn_sel)};
      end
   end

   assign q_dmem = rd_sel_q ? rd_val_q : q_ram;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         // Sampling btn here means a button held through reset yields no event.
         btn_prev_q <= btn;
         pending_q  <= '0;
         rd_sel_q   <= 1'b0;
         rd_val_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         btn_prev_q <= btn;
         pending_q  <= pending_d;
         rd_sel_q   <= rd_sel_d;
         rd_val_q   <= rd_val_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // FIFO storage carries no reset; out_data is masked while empty.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data;
      end
   end

endmodule

// File: tb/tb_mmio_io_bridge.sv
// -----------------------------------------------------------------------------
// tb_mmio_io_bridge
//
// Directed bench for mmio_io_bridge. Stimulus pushes expected load results and
// expected FIFO drain words into queues; a monitor pops and compares whenever
// a tagged load result is due or the FIFO hands off a word. A small 256-word
// RAM stub with 1-cycle read latency sits behind q_ram.
// -----------------------------------------------------------------------------
module tb_mmio_io_bridge;

   logic        clock;
   logic        reset;
   logic [31:0] address;
   logic        wren;
   logic [31:0] data;
   logic [31:0] q_ram;
   logic [31:0] q_dmem;
   logic        ram_wren;
   logic [4:0]  btn;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;

   int errors = 0;
   int checks = 0;

   logic [31:0] ld_q[$];
   logic [31:0] fifo_q[$];
   logic        ld_tag;
   logic        ld_tag_p1;
   logic [31:0] ram [0:255];

   mmio_io_bridge dut (
      .clock        (clock),
      .reset        (reset),
      .address_dmem (address),
      .wren         (wren),
      .data         (data),
      .q_ram        (q_ram),
      .q_dmem       (q_dmem),
      .ram_wren     (ram_wren),
      .btn          (btn),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RAM stub: 1-cycle read latency, old data on read-during-write.
   always @(posedge clock) begin
      if (ram_wren) ram[address[7:0]] <= data;
      q_ram <= ram[address[7:0]];
   end

   always @(posedge clock) ld_tag_p1 <= ld_tag;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (ld_tag_p1) begin
         if (ld_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ld_unexpected: got 0x%08h expected no load", q_dmem);
         end else begin
            check("q_dmem", q_dmem, ld_q.pop_front());
         end
      end
      if (out_valid && out_ready) begin
         if (fifo_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fifo_unexpected: got 0x%08h expected no word", out_data);
         end else begin
            check("out_data", out_data, fifo_q.pop_front());
         end
      end
   end

   // One processor access per cycle, driven 1 time unit after the rising edge.
   task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic tag, input logic [31:0] exp);
      @(posedge clock);
      #1;
      wren    = w;
      address = a;
      data    = d;
      ld_tag  = tag;
      if (tag) ld_q.push_back(exp);
   endtask

   task automatic idle();
      op(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] exp);
      op(1'b0, a, 32'd0, 1'b1, exp);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic exp_wren);
      op(1'b1, a, d, 1'b0, 32'd0);
      #1;
      check("ram_wren", {31'd0, ram_wren}, {31'd0, exp_wren});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'd0;
      q_ram     = 32'd0;
      reset     = 1'b1;
      btn       = 5'b00100;   // R held through reset
      wren      = 1'b0;
      address   = 32'd0;
      data      = 32'd0;
      out_ready = 1'b0;
      ld_tag    = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data",  out_data, 32'd0);
      check("rst_q_dmem",    q_dmem,   32'd0);
      check("rst_ram_wren",  {31'd0, ram_wren}, 32'd0);
      reset = 1'b0;

      // Held button released after reset: no event.
      idle();
      idle();
      btn = 5'b00000;
      idle();
      load(32'd4000, 32'd0);

      // Centre pulse, then clear-on-read.
      idle();
      btn = 5'b00001;
      idle();
      btn = 5'b00000;
      load(32'd1000, 32'd1);
      load(32'd1000, 32'd0);

      // Left rise in the same cycle as its read: read 0, event survives.
      load(32'd3000, 32'd0);
      btn = 5'b00010;
      load(32'd3000, 32'd1);
      load(32'd3000, 32'd0);
      idle();
      btn = 5'b00000;

      // Down pulse; up untouched.
      idle();
      btn = 5'b10000;
      idle();
      btn = 5'b00000;
      load(32'd6000, 32'd1);
      load(32'd5000, 32'd0);

      // Fill FIFO with consumer stalled, fifth store dropped.
      store(32'd2000, 32'h11, 1'b0); fifo_q.push_back(32'h11);
      store(32'd2000, 32'h22, 1'b0); fifo_q.push_back(32'h22);
      store(32'd2000, 32'h33, 1'b0); fifo_q.push_back(32'h33);
      store(32'd2000, 32'h44, 1'b0); fifo_q.push_back(32'h44);
      store(32'd2000, 32'h55, 1'b0);
      load(32'd2004, 32'h0001_0004);

      // Store into a full FIFO while the head is popped: accepted, no drop.
      op(1'b1, 32'd2000, 32'h66, 1'b0, 32'd0);
      out_ready = 1'b1;
      fifo_q.push_back(32'h66);
      #1;
      check("ram_wren", {31'd0, ram_wren}, 32'd0);
      idle();
      out_ready = 1'b0;
      load(32'd2004, 32'h0001_0004);

      // Drain the rest.
      idle();
      out_ready = 1'b1;
      repeat (5) idle();
      out_ready = 1'b0;
      load(32'd2004, 32'h0001_0000);
      load(32'd2000, 32'd0);

      // Plain RAM traffic and ignored MMIO stores.
      store(32'd12, 32'h0000_ABCD, 1'b1);
      load(32'd12, 32'h0000_ABCD);
      store(32'd1000, 32'd5, 1'b0);
      store(32'd2004, 32'd9, 1'b0);
      load(32'd2004, 32'h0001_0000);

      // Reset in the middle of activity.
      store(32'd2000, 32'h77, 1'b0);
      btn = 5'b01000;
      idle();
      load(32'd2004, 32'h0001_0001);
      idle();
      reset = 1'b1;
      idle();
      reset = 1'b0;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_out_data",  out_data, 32'd0);
      idle();
      btn = 5'b00000;
      load(32'd5000, 32'd0);
      load(32'd2004, 32'd0);
      repeat (3) idle();

      check("ld_queue_left",   ld_q.size(),   32'd0);
      check("fifo_queue_left", fifo_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
